// File: rtl/fifo_umbral.sv
// Synchronous FIFO with registered read port, occupancy count and live-threshold
// almost-empty / almost-full flags for a flow-control FSM.
module fifo_umbral #(
    parameter int unsigned DATA_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [UMBRALES_L_H-1:0] umbral_L,
    input  logic [UMBRALES_L_H-1:0] umbral_H,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic                    pop_ok, push_ok;
    logic [UMBRALES_L_H-1:0] count_ext;

    always_comb begin
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        error_d  = error_q | (push & ~push_ok) | (pop & ~pop_ok);

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            data_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Storage is never reset; a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign count_ext    = UMBRALES_L_H'(count_q);
    assign empty        = (count_q == '0);
    assign full         = (count_q == DepthCount);
    assign almost_empty = (count_ext <= umbral_L);
    assign almost_full  = (count_ext >= umbral_H);
    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign error        = error_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: queue scoreboard for read data plus a
// vector table for the threshold flags across a full fill/drain sweep.
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop;
    logic [5:0] data_in;
    logic [7:0] umbral_L, umbral_H;
    logic [5:0] data_out;
    logic       valid_out, empty, full, almost_empty, almost_full, error;
    logic [3:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] mq[$];
    logic [5:0] mlast;
    bit         merr;

    typedef struct {
        bit push;
        bit pop;
        int exp_count;
        bit exp_ae;
        bit exp_af;
    } vec_t;
    vec_t vt[16];

    fifo_umbral dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .umbral_L    (umbral_L),
        .umbral_H    (umbral_H),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .error       (error),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mlast = '0;
        merr  = 1'b0;
    endtask

    // One clock with the given inputs; outputs checked 1 time unit after the edge.
    task automatic cycle(input bit p, input bit q, input logic [5:0] d);
        bit         pop_ok, push_ok;
        logic [5:0] w;
        int         n;
        n       = mq.size();
        pop_ok  = q && (n != 0);
        push_ok = p && ((n != 8) || pop_ok);
        if ((p && !push_ok) || (q && !pop_ok)) merr = 1'b1;
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        if (pop_ok) begin
            w     = mq.pop_front();
            mlast = w;
        end
        if (push_ok) mq.push_back(d);
        chk("valid_out", 32'(valid_out), 32'(pop_ok));
        chk("data_out", 32'(data_out), 32'(mlast));
        chk("count", 32'(count), 32'(mq.size()));
        chk("error", 32'(error), 32'(merr));
    endtask

    initial begin
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        umbral_L = 8'd1;
        umbral_H = 8'd6;
        reset    = 1'b0;
        #2;

        // Reset state
        reset = 1'b1;
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst almost_empty", 32'(almost_empty), 32'd1);
        chk("rst almost_full", 32'(almost_full), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst valid_out", 32'(valid_out), 32'd0);
        umbral_H = 8'd0;
        #1;
        chk("rst umbral_H=0 almost_full", 32'(almost_full), 32'd1);
        umbral_H = 8'd6;
        do_reset();

        // Fill with 0x01..0x08, then drain in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
        chk("full after 8 pushes", 32'(full), 32'd1);
        umbral_L = 8'd8;
        #1;
        chk("umbral_L=DEPTH almost_empty", 32'(almost_empty), 32'd1);
        umbral_L = 8'd1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00);
        cycle(1'b0, 1'b0, 6'h00);
        chk("empty after drain", 32'(empty), 32'd1);

        // Rejected push when full
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
        cycle(1'b1, 1'b0, 6'h2A);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 6'h00);
            if (data_out == 6'h2A) chk("dropped word seen", 32'(data_out), 32'h0);
        end

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
        cycle(1'b1, 1'b1, 6'h15);
        chk("full push+pop data", 32'(data_out), 32'h01);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00);
        chk("last drained word", 32'(data_out), 32'h15);

        // Threshold sweep 0 -> 8 -> 0 with umbral_L = 2, umbral_H = 6
        do_reset();
        umbral_L = 8'd2;
        umbral_H = 8'd6;
        for (int i = 0; i < 8; i++) begin
            vt[i].push      = 1'b1;
            vt[i].pop       = 1'b0;
            vt[i].exp_count = i + 1;
            vt[i].exp_ae    = (i + 1) <= 2;
            vt[i].exp_af    = (i + 1) >= 6;
            vt[8+i].push      = 1'b0;
            vt[8+i].pop       = 1'b1;
            vt[8+i].exp_count = 7 - i;
            vt[8+i].exp_ae    = (7 - i) <= 2;
            vt[8+i].exp_af    = (7 - i) >= 6;
        end
        #1;
        chk("sweep ae at 0", 32'(almost_empty), 32'd1);
        chk("sweep af at 0", 32'(almost_full), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cycle(vt[i].push, vt[i].pop, 6'(8'h10 + i));
            chk("sweep count", 32'(count), 32'(vt[i].exp_count));
            chk("sweep almost_empty", 32'(almost_empty), 32'(vt[i].exp_ae));
            chk("sweep almost_full", 32'(almost_full), 32'(vt[i].exp_af));
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'(i));
        chk("af at 4 with H=6", 32'(almost_full), 32'd0);
        umbral_H = 8'd3;
        #1;
        chk("af at 4 with H=3", 32'(almost_full), 32'd1);

        // Pop on empty, push+pop on empty, then reset mid-fill
        do_reset();
        umbral_L = 8'd1;
        umbral_H = 8'd6;
        cycle(1'b0, 1'b1, 6'h00);
        chk("error after empty pop", 32'(error), 32'd1);
        cycle(1'b1, 1'b1, 6'h0C);
        chk("empty push+pop count", 32'(count), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'(i + 32));
        chk("count before reset", 32'(count), 32'd5);
        reset = 1'b1;
        #1;
        chk("async reset count", 32'(count), 32'd0);
        chk("async reset error", 32'(error), 32'd0);
        do_reset();
        cycle(1'b1, 1'b0, 6'h33);
        cycle(1'b0, 1'b1, 6'h00);
        chk("first word after reset", 32'(data_out), 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
